// File: rtl/life_array16x16_if.sv
// Tile access bus for the 16x16 Game-of-Life array: tile write, tile read
// and the step request.
interface life_array16x16_if;
    logic [15:0] vali;
    logic [3:0]  vali_selector;
    logic [3:0]  valo_selector;
    logic        write_enb;
    logic        step;
    logic [15:0] valo;
    logic [15:0] valo_prev;

    modport master (
        output vali, vali_selector, valo_selector, write_enb, step,
        input  valo, valo_prev
    );

    modport slave (
        input  vali, vali_selector, valo_selector, write_enb, step,
        output valo, valo_prev
    );
endinterface

// File: rtl/life_array16x16.sv
// 16x16 Conway Game-of-Life array with 4x4-tile access port and tileable
// edge/corner neighbour exchange.
module life_array16x16 (
    input  logic                 clk,
    input  logic                 reset,
    life_array16x16_if.slave     bus,
    input  logic [15:0]          ni,
    input  logic [15:0]          si,
    input  logic [15:0]          wi,
    input  logic [15:0]          ei,
    input  logic                 nwi,
    input  logic                 nei,
    input  logic                 sei,
    input  logic                 swi,
    output logic [15:0]          no,
    output logic [15:0]          so,
    output logic [15:0]          wo,
    output logic [15:0]          eo,
    output logic                 nwo,
    output logic                 neo,
    output logic                 seo,
    output logic                 swo
);

    // Cell (x,y) lives at flat index y*16+x.
    logic [255:0] r_cur;
    logic [255:0] r_prev;
    logic [255:0] w_next;
    logic [255:0] w_written;
    logic [17:0]  w_pad [18];

    // Tile T / bit b to flat index: x = {T[3:2],b[3:2]}, y = {T[1:0],b[1:0]}.
    function automatic logic [7:0] cell_idx(input logic [3:0] t, input logic [3:0] b);
        return {t[1:0], b[1:0], t[3:2], b[3:2]};
    endfunction

    // Array framed by the neighbour ring; pad (x+1,y+1) holds cell (x,y).
    always_comb begin
        w_pad[0]  = {nei, ni, nwi};
        w_pad[17] = {sei, si, swi};
        for (int y = 0; y < 16; y++) begin
            w_pad[y+1] = {ei[y], r_cur[y*16 +: 16], wi[y]};
        end
    end

    // Next generation for every cell from the pre-edge state.
    always_comb begin
        logic [3:0] cnt;
        w_next = 256'd0;
        cnt    = 4'd0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                cnt = 4'd0;
                for (int dy = 0; dy < 3; dy++) begin
                    for (int dx = 0; dx < 3; dx++) begin
                        if (!(dy == 1 && dx == 1)) begin
                            cnt = cnt + {3'd0, w_pad[y+dy][x+dx]};
                        end else begin
                            cnt = cnt;
                        end
                    end
                end
                w_next[y*16+x] = (cnt == 4'd3) || (r_cur[y*16+x] && (cnt == 4'd2));
            end
        end
    end

    // Current state with the selected tile replaced by the write data.
    always_comb begin
        w_written = r_cur;
        for (int b = 0; b < 16; b++) begin
            w_written[cell_idx(bus.vali_selector, 4'(b))] = bus.vali[b];
        end
    end

    // Cell state: reset beats write, write beats step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur  <= 256'd0;
            r_prev <= 256'd0;
        end else if (bus.write_enb) begin
            r_cur  <= w_written;
        end else if (bus.step) begin
            r_prev <= r_cur;
            r_cur  <= w_next;
        end else begin
            r_cur  <= r_cur;
            r_prev <= r_prev;
        end
    end

    // Tile read-back of current and previous generation.
    always_comb begin
        bus.valo      = 16'd0;
        bus.valo_prev = 16'd0;
        for (int b = 0; b < 16; b++) begin
            bus.valo[b]      = r_cur[cell_idx(bus.valo_selector, 4'(b))];
            bus.valo_prev[b] = r_prev[cell_idx(bus.valo_selector, 4'(b))];
        end
    end

    // Edge and corner export for neighbouring arrays.
    always_comb begin
        no = r_cur[15:0];
        so = r_cur[255:240];
        wo = 16'd0;
        eo = 16'd0;
        for (int y = 0; y < 16; y++) begin
            wo[y] = r_cur[y*16];
            eo[y] = r_cur[y*16+15];
        end
        nwo = r_cur[0];
        neo = r_cur[15];
        swo = r_cur[240];
        seo = r_cur[255];
    end

endmodule

// File: tb/tb_life_array16x16.sv
// Self-checking bench for life_array16x16: directed table vectors, corner
// sequences, and randomized traffic against a cell-level Life model.
module tb_life_array16x16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ni, si, wi, ei;
    logic        nwi, nei, sei, swi;
    logic [15:0] no, so, wo, eo;
    logic        nwo, neo, seo, swo;

    int checks = 0;
    int errors = 0;

    bit m_cur  [16][16];   // [x][y]
    bit m_prev [16][16];

    life_array16x16_if bus ();

    life_array16x16 dut (
        .clk(clk), .reset(reset), .bus(bus),
        .ni(ni), .si(si), .wi(wi), .ei(ei),
        .nwi(nwi), .nei(nei), .sei(sei), .swi(swi),
        .no(no), .so(so), .wo(wo), .eo(eo),
        .nwo(nwo), .neo(neo), .seo(seo), .swo(swo)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic [255:0] init;
        int           nsteps;
        bit           chk_prev;
        logic [255:0] exp_cur;
        logic [255:0] exp_prev;
        logic [15:0]  exp_no;
        logic [15:0]  exp_wo;
        logic [15:0]  exp_so;
        logic [3:0]   exp_corn;   // {nwo,neo,seo,swo}
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] t, input logic [15:0] d);
        bus.vali_selector = t;
        bus.vali          = d;
        bus.write_enb     = 1'b1;
        tick();
        bus.write_enb     = 1'b0;
    endtask

    task automatic do_step();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
    endtask

    task automatic read_tile(input logic [3:0] t, output logic [15:0] c, output logic [15:0] p);
        bus.valo_selector = t;
        #1;
        c = bus.valo;
        p = bus.valo_prev;
    endtask

    // ---------------- reference model ----------------
    function automatic bit cell_at(input int x, input int y);
        if (x >= 0 && x < 16 && y >= 0 && y < 16) return m_cur[x][y];
        if (y == -1) begin
            if (x == -1) return nwi;
            if (x == 16) return nei;
            return ni[x];
        end
        if (y == 16) begin
            if (x == -1) return swi;
            if (x == 16) return sei;
            return si[x];
        end
        if (x == -1) return wi[y];
        return ei[y];
    endfunction

    task automatic model_step();
        bit nxt [16][16];
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                int n = 0;
                for (int dx = -1; dx <= 1; dx++)
                    for (int dy = -1; dy <= 1; dy++)
                        if (dx != 0 || dy != 0) n += int'(cell_at(x+dx, y+dy));
                nxt[x][y] = (n == 3) || (m_cur[x][y] && n == 2);
            end
        end
        m_prev = m_cur;
        m_cur  = nxt;
    endtask

    task automatic model_clear();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                m_cur[x][y]  = 1'b0;
                m_prev[x][y] = 1'b0;
            end
    endtask

    task automatic model_write(input logic [3:0] t, input logic [15:0] d);
        for (int b = 0; b < 16; b++)
            m_cur[4*int'(t[3:2]) + b/4][4*int'(t[1:0]) + b%4] = d[b];
    endtask

    function automatic logic [15:0] model_tile(input logic [3:0] t, input bit prev);
        logic [15:0] r = 16'h0000;
        for (int b = 0; b < 16; b++) begin
            int x = 4*int'(t[3:2]) + b/4;
            int y = 4*int'(t[1:0]) + b%4;
            r[b] = prev ? m_prev[x][y] : m_cur[x][y];
        end
        return r;
    endfunction

    task automatic check_model(input int cyc);
        logic [15:0] c, p, e_no, e_so, e_wo, e_eo;
        for (int t = 0; t < 16; t++) begin
            read_tile(4'(t), c, p);
            chk($sformatf("rnd%0d_cur_T%0d", cyc, t), c, model_tile(4'(t), 1'b0));
            chk($sformatf("rnd%0d_prev_T%0d", cyc, t), p, model_tile(4'(t), 1'b1));
        end
        for (int i = 0; i < 16; i++) begin
            e_no[i] = m_cur[i][0];
            e_so[i] = m_cur[i][15];
            e_wo[i] = m_cur[0][i];
            e_eo[i] = m_cur[15][i];
        end
        chk($sformatf("rnd%0d_no", cyc), no, e_no);
        chk($sformatf("rnd%0d_so", cyc), so, e_so);
        chk($sformatf("rnd%0d_wo", cyc), wo, e_wo);
        chk($sformatf("rnd%0d_eo", cyc), eo, e_eo);
        chk($sformatf("rnd%0d_corners", cyc), {12'h000, nwo, neo, seo, swo},
            {12'h000, m_cur[0][0], m_cur[15][0], m_cur[15][15], m_cur[0][15]});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] c, p;
        reset = 1'b1;
        ni = 16'h0; si = 16'h0; wi = 16'h0; ei = 16'h0;
        nwi = 1'b0; nei = 1'b0; sei = 1'b0; swi = 1'b0;
        bus.vali = 16'h0; bus.vali_selector = 4'h0; bus.valo_selector = 4'h0;
        bus.write_enb = 1'b0; bus.step = 1'b0;

        for (int v = 0; v < 6; v++) begin
            vecs[v].init = 256'd0; vecs[v].nsteps = 0; vecs[v].chk_prev = 1'b1;
            vecs[v].exp_cur = 256'd0; vecs[v].exp_prev = 256'd0;
            vecs[v].exp_no = 16'h0; vecs[v].exp_wo = 16'h0; vecs[v].exp_so = 16'h0;
            vecs[v].exp_corn = 4'h0;
        end
        // single cell at origin
        vecs[0].init[15:0] = 16'h0001; vecs[0].exp_cur[15:0] = 16'h0001;
        vecs[0].exp_no = 16'h0001; vecs[0].exp_wo = 16'h0001; vecs[0].exp_corn = 4'b1000;
        // full top row
        for (int t = 0; t < 16; t += 4) begin
            vecs[1].init[t*16 +: 16] = 16'h1111; vecs[1].exp_cur[t*16 +: 16] = 16'h1111;
        end
        vecs[1].exp_no = 16'hFFFF; vecs[1].exp_wo = 16'h0001; vecs[1].exp_corn = 4'b1100;
        // still-life block
        vecs[2].init[15:0] = 16'h0660; vecs[2].nsteps = 1;
        vecs[2].exp_cur[15:0] = 16'h0660; vecs[2].exp_prev[15:0] = 16'h0660;
        // blinker, one and two steps
        vecs[3].init[15:0] = 16'h0222; vecs[3].nsteps = 1;
        vecs[3].exp_cur[15:0] = 16'h0070; vecs[3].exp_prev[15:0] = 16'h0222;
        vecs[3].exp_no = 16'h0002;
        vecs[4].init[15:0] = 16'h0222; vecs[4].nsteps = 2;
        vecs[4].exp_cur[15:0] = 16'h0222; vecs[4].exp_prev[15:0] = 16'h0070;
        vecs[4].exp_wo = 16'h0002;
        // figure-8, period 8
        vecs[5].init[5*16 +: 16] = 16'hEEE0; vecs[5].init[10*16 +: 16] = 16'h0777;
        vecs[5].exp_cur = vecs[5].init; vecs[5].nsteps = 8; vecs[5].chk_prev = 1'b0;

        tick();
        reset = 1'b0;
        for (int t = 0; t < 16; t++) begin
            read_tile(4'(t), c, p);
            chk($sformatf("reset_cur_T%0d", t), c, 16'h0000);
            chk($sformatf("reset_prev_T%0d", t), p, 16'h0000);
        end

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int t = 0; t < 16; t++)
                if (vecs[v].init[t*16 +: 16] != 16'h0000) do_write(4'(t), vecs[v].init[t*16 +: 16]);
            repeat (vecs[v].nsteps) do_step();
            for (int t = 0; t < 16; t++) begin
                read_tile(4'(t), c, p);
                chk($sformatf("v%0d_cur_T%0d", v, t), c, vecs[v].exp_cur[t*16 +: 16]);
                if (vecs[v].chk_prev)
                    chk($sformatf("v%0d_prev_T%0d", v, t), p, vecs[v].exp_prev[t*16 +: 16]);
            end
            chk($sformatf("v%0d_no", v), no, vecs[v].exp_no);
            chk($sformatf("v%0d_wo", v), wo, vecs[v].exp_wo);
            chk($sformatf("v%0d_so", v), so, vecs[v].exp_so);
            chk($sformatf("v%0d_corners", v), {12'h000, nwo, neo, seo, swo}, {12'h000, vecs[v].exp_corn});
        end

        // write and step on the same edge: write wins, no generation advance
        do_reset();
        do_write(4'h0, 16'h0222);
        bus.vali_selector = 4'h3; bus.vali = 16'h1234;
        bus.write_enb = 1'b1; bus.step = 1'b1;
        tick();
        bus.write_enb = 1'b0; bus.step = 1'b0;
        read_tile(4'h0, c, p);
        chk("wr_step_T0_cur", c, 16'h0222);
        chk("wr_step_T0_prev", p, 16'h0000);
        read_tile(4'h3, c, p);
        chk("wr_step_T3_cur", c, 16'h1234);

        // reset mid-run clears everything including exported edges
        do_write(4'hF, 16'hFFFF);
        do_step();
        do_reset();
        read_tile(4'hF, c, p);
        chk("midrst_T15_cur", c, 16'h0000);
        chk("midrst_T15_prev", p, 16'h0000);
        read_tile(4'h0, c, p);
        chk("midrst_T0_prev", p, 16'h0000);
        chk("midrst_so", so, 16'h0000);
        chk("midrst_eo", eo, 16'h0000);
        chk("midrst_corners", {12'h000, nwo, neo, seo, swo}, 16'h0000);

        // birth driven purely by the north neighbour row
        ni = 16'h0007;
        do_step();
        ni = 16'h0000;
        chk("north_birth_no", no, 16'h0002);
        read_tile(4'h0, c, p);
        chk("north_birth_T0", c, 16'h0010);

        // randomized traffic against the model
        do_reset();
        model_clear();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 3) == 0) begin
                ni = 16'h0; si = 16'h0; wi = 16'h0; ei = 16'h0;
                nwi = 1'b0; nei = 1'b0; sei = 1'b0; swi = 1'b0;
            end else begin
                ni = 16'($urandom); si = 16'($urandom); wi = 16'($urandom); ei = 16'($urandom);
                {nwi, nei, sei, swi} = 4'($urandom);
            end
            bus.write_enb     = (r < 15);
            bus.step          = (r >= 10 && r < 80);
            reset             = (r >= 97);
            bus.vali_selector = 4'($urandom);
            bus.vali          = 16'($urandom);
            if (reset) model_clear();
            else if (bus.write_enb) model_write(bus.vali_selector, bus.vali);
            else if (bus.step) model_step();
            tick();
            reset = 1'b0; bus.write_enb = 1'b0; bus.step = 1'b0;
            check_model(cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
